// File: rtl/sram_port_master.sv
// sram_port_master
//   Initiator for one port of a single-clock dual-port SRAM with cs/oe/we
//   control and a shared bidirectional data bus. A valid/ready request stream
//   is turned into registered chip-select, output-enable, write-enable,
//   address and bus-drive activity. Completed reads return a one-cycle
//   rsp_valid pulse with rsp_rdata, which holds until the next read finishes.
//
//   Optional feature macro: SRAM_PORT_MASTER_TURNAROUND_EN
//     Defined   - a write accepted in RD_DATA first spends one TURN cycle with
//                 cs=0 and the bus released, then enters WRITE.
//     Undefined - RD_DATA goes straight to WRITE, relying on the RAM releasing
//                 its output at the same edge.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  request handshake
//   req_we, req_addr,
//   req_wdata            request: 1=write/0=read, address, write data
//   rsp_valid, rsp_rdata read response pulse and held read data
//   cs, oe, we, address  registered RAM control and address
//   data                 RAM data bus, driven only during WRITE
module sram_port_master #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              cs,
  output logic              oe,
  output logic              we,
  output logic [AWIDTH-1:0] address,
  inout  wire  [DWIDTH-1:0] data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_ADDR,
    S_RD_DATA
`ifdef SRAM_PORT_MASTER_TURNAROUND_EN
    , S_TURN
`endif
  } state_t;

  state_t            state_q, state_d;
  logic              accept;
  logic              cs_d, oe_d, we_d, drive_d;
  logic              drive_q;
  logic [AWIDTH-1:0] address_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
`ifdef SRAM_PORT_MASTER_TURNAROUND_EN
  // Address of the write parked in TURN; the RAM address pins keep the read
  // address during TURN, so the new one must be stored separately.
  logic [AWIDTH-1:0] pend_addr_q;
`endif

  // req_ready is a decode of the registered state only
`ifdef SRAM_PORT_MASTER_TURNAROUND_EN
  assign req_ready = (state_q != S_RD_ADDR) && (state_q != S_TURN);
`else
  assign req_ready = (state_q != S_RD_ADDR);
`endif

  assign accept = req_valid && req_ready;

  // Pin values are derived from the next state so that every RAM-facing
  // signal comes straight out of a flop in the cycle the state is entered.
  always_comb begin
    state_d   = state_q;
    address_d = address;
    wdata_d   = wdata_q;
    case (state_q)
      S_RD_ADDR: state_d = S_RD_DATA;
`ifdef SRAM_PORT_MASTER_TURNAROUND_EN
      S_TURN:    state_d = S_WRITE;
`endif
      default: begin
        if (!accept) begin
          state_d = S_IDLE;
        end else if (req_we) begin
          state_d = S_WRITE;
`ifdef SRAM_PORT_MASTER_TURNAROUND_EN
          if (state_q == S_RD_DATA) state_d = S_TURN;
`endif
        end else begin
          state_d = S_RD_ADDR;
        end
      end
    endcase

    if (accept && req_we) wdata_d = req_wdata;
`ifdef SRAM_PORT_MASTER_TURNAROUND_EN
    if (state_q == S_TURN) address_d = pend_addr_q;
    else if (accept && state_d != S_TURN) address_d = req_addr;
`else
    if (accept) address_d = req_addr;
`endif

    cs_d    = (state_d == S_WRITE) || (state_d == S_RD_ADDR) || (state_d == S_RD_DATA);
    oe_d    = (state_d == S_RD_ADDR) || (state_d == S_RD_DATA);
    we_d    = (state_d == S_WRITE);
    drive_d = (state_d == S_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cs          <= 1'b0;
      oe          <= 1'b0;
      we          <= 1'b0;
      drive_q     <= 1'b0;
      address     <= '0;
      wdata_q     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
`ifdef SRAM_PORT_MASTER_TURNAROUND_EN
      pend_addr_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cs        <= cs_d;
      oe        <= oe_d;
      we        <= we_d;
      drive_q   <= drive_d;
      address   <= address_d;
      wdata_q   <= wdata_d;
      // RAM drives the bus during RD_DATA; capture at the end of that cycle
      rsp_valid <= (state_q == S_RD_DATA);
      if (state_q == S_RD_DATA) rsp_rdata <= data;
`ifdef SRAM_PORT_MASTER_TURNAROUND_EN
      if (accept) pend_addr_q <= req_addr;
`endif
    end
  end

  assign data = drive_q ? wdata_q : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_sram_port_master.sv
module tb_sram_port_master;

`ifdef SRAM_PORT_MASTER_TURNAROUND_EN
  localparam bit TURN_EN = 1'b1;
`else
  localparam bit TURN_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       cs, oe, we;
  logic [7:0] address;
  wire  [7:0] data_bus;

  sram_port_master #(.DWIDTH(8), .AWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cs(cs), .oe(oe), .we(we), .address(address), .data(data_bus)
  );

  always #5 clk = ~clk;

  // RAM port: registers the read at the end of the first cs&oe cycle and
  // drives the bus for exactly the following cycle.
  logic [7:0] ram [256];
  logic [7:0] ram_q = '0;
  logic       ram_drive = 1'b0;
  assign data_bus = ram_drive ? ram_q : 8'bz;

  always @(posedge clk) begin
    if (cs && we) ram[address] <= data_bus;
    if (cs && oe && !we && !ram_drive) begin
      ram_q     <= ram[address];
      ram_drive <= 1'b1;
    end else begin
      ram_drive <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s @cyc %0d", name, cyc);
  endtask

  // Reference model: memory image plus per-cycle expectations
  typedef struct { logic [7:0] d; int due; } exp_t;
  exp_t       rd_q[$];
  exp_t       wr_q[$];
  bit         wr_cyc[int];
  bit         rd_cyc[int];
  bit         ready_low[int];
  logic [7:0] addr_at[int];
  logic [7:0] ref_mem [256];
  logic [7:0] last_rd = '0;
  int         last_rd_c = -100;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end
  end

  // Called at the negedge before the edge that accepts the request.
  task automatic accept_model(input logic w, input logic [7:0] a, input logic [7:0] d);
    int   c;
    exp_t e;
    c = cyc;
    if (w) begin
      e.due = c + 1;
      if (TURN_EN && c == last_rd_c + 2) begin
        e.due = c + 2;
        ready_low[c+1] = 1'b1;
      end
      e.d = d;
      wr_cyc[e.due]  = 1'b1;
      addr_at[e.due] = a;
      wr_q.push_back(e);
      ref_mem[a] = d;
    end else begin
      rd_cyc[c+1]    = 1'b1;
      rd_cyc[c+2]    = 1'b1;
      addr_at[c+1]   = a;
      addr_at[c+2]   = a;
      ready_low[c+1] = 1'b1;
      e.d   = ref_mem[a];
      e.due = c + 3;
      rd_q.push_back(e);
      last_rd_c = c;
    end
  endtask

  // Driver: entered at a negedge, returns at a negedge.
  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d);
    int budget;
    budget = 0;
    req_valid = 1'b1;
    req_we    = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      flag("req_ready_timeout");
      req_valid = 1'b0;
    end else begin
      accept_model(w, a, d);
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: checks pins every cycle and pops the scoreboards on activity
  exp_t m;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cs", 32'(cs), 32'(wr_cyc.exists(cyc) || rd_cyc.exists(cyc)));
      chk("oe", 32'(oe), 32'(rd_cyc.exists(cyc)));
      chk("we", 32'(we), 32'(wr_cyc.exists(cyc)));
      chk("req_ready", 32'(req_ready), 32'(!ready_low.exists(cyc)));
      if (addr_at.exists(cyc)) chk("address", 32'(address), 32'(addr_at[cyc]));
      chk("bus_contention", 32'(we && ram_drive), 32'(0));
      while (wr_q.size() > 0 && wr_q[0].due < cyc) begin
        void'(wr_q.pop_front());
        flag("write_missing");
      end
      while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
        void'(rd_q.pop_front());
        flag("rsp_missing");
      end
      if (cs && we) begin
        if (wr_q.size() == 0) flag("write_unexpected");
        else begin
          m = wr_q.pop_front();
          chk("wr_data", 32'(data_bus), 32'(m.d));
          chk("wr_cycle", 32'(cyc), 32'(m.due));
        end
      end
      if (rsp_valid) begin
        if (rd_q.size() == 0) flag("rsp_unexpected");
        else begin
          m = rd_q.pop_front();
          chk("rsp_cycle", 32'(cyc), 32'(m.due));
          last_rd = m.d;
        end
      end
      chk("rsp_rdata", 32'(rsp_rdata), 32'(last_rd));
    end
  end

  initial begin
    // Reset from time 0, then a write interrupted by reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("ready_after_reset", 32'(req_ready), 32'(1));
    chk("address_reset", 32'(address), 32'(0));
    chk("rdata_reset", 32'(rsp_rdata), 32'(0));
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h80; req_wdata = 8'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("mid_write_cs", 32'(cs), 32'(1));
    chk("mid_write_we", 32'(we), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_cs", 32'(cs), 32'(0));
    chk("async_rst_we", 32'(we), 32'(0));
    chk("async_rst_oe", 32'(oe), 32'(0));
    chk("async_rst_rsp", 32'(rsp_valid), 32'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_release", 32'(req_ready), 32'(1));
    @(negedge clk);

    // Single write then read
    send(1'b1, 8'h3C, 8'hA5);
    send(1'b0, 8'h3C, 8'h00);
    idle(4);
    chk("last_read_3c", 32'(last_rd), 32'(8'hA5));

    // Write burst, then read burst
    for (int i = 0; i < 4; i++) send(1'b1, 8'(i), 8'(8'h10 + i));
    for (int i = 1; i < 4; i++) send(1'b0, 8'(i), 8'h00);
    idle(4);
    chk("last_read_burst", 32'(last_rd), 32'(8'h13));

    // Read followed by a write presented during RD_DATA
    send(1'b1, 8'h05, 8'h5A);
    send(1'b0, 8'h05, 8'h00);
    send(1'b1, 8'h06, 8'h77);
    idle(4);

    // Read then hold idle for 10 cycles
    send(1'b0, 8'h05, 8'h00);
    idle(10);
    chk("idle_hold_rdata", 32'(rsp_rdata), 32'(8'h5A));

    // Randomized traffic over a small address window
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
    end
    idle(8);

    chk("wr_queue_drained", 32'(wr_q.size()), 32'(0));
    chk("rd_queue_drained", 32'(rd_q.size()), 32'(0));
    for (int i = 0; i < 256; i++) chk("ram_contents", 32'(ram[i]), 32'(ref_mem[i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_port_master.md
# sram_port_master

Synchronous initiator for one port of the team's single-clock dual-port SRAM (cs/oe/we control, shared bidirectional data bus). It converts a valid/ready request stream and a one-cycle response pulse into correctly sequenced chip-select, output-enable, write-enable, address and data-bus activity. It sits between a client (DMA engine, CPU bridge) and one RAM port. Two instances can drive both ports of the same RAM.

## Interface
Parameters:
- DWIDTH, 8, data bus width in bits
- AWIDTH, 8, address width in bits

Ports:
- clk  input  1  single clock; all flops on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- req_valid  input  1  client request valid
- req_ready  output  1  block can accept a request this cycle
- req_we  input  1  1 = write, 0 = read
- req_addr  input  AWIDTH  request address
- req_wdata  input  DWIDTH  write data
- rsp_valid  output  1  one-cycle pulse; rsp_rdata is valid
- rsp_rdata  output  DWIDTH  read data, held until the next read completes
- cs  output  1  RAM chip select
- oe  output  1  RAM output enable
- we  output  1  RAM write enable
- address  output  AWIDTH  RAM address
- data  inout  DWIDTH  RAM data bus; driven only in WRITE, otherwise high-Z

## Operation
- A request is accepted on a rising edge where req_valid && req_ready. Address, we and wdata are captured at that edge.
- cs, oe, we, address, the write-data register and the bus-drive enable are all registered. Nothing combinational drives the RAM pins.
- FSM states and outputs:
  - IDLE: cs=0, oe=0, we=0, bus high-Z, req_ready=1.
  - WRITE: cs=1, we=1, oe=0, data driven with the captured wdata, req_ready=1.
  - RD_ADDR: cs=1, oe=1, we=0, bus high-Z, req_ready=0. The RAM registers the read at the end of this cycle.
  - RD_DATA: controls held exactly as in RD_ADDR, so the RAM drives the bus. The block samples data into rsp_rdata at the end of this cycle. req_ready=1.
  - TURN: present only with the macro. cs=0, bus high-Z, req_ready=0, one pending write is held.
- Transitions:
  - IDLE, WRITE or RD_DATA with an accepted write goes to WRITE. The one exception: from RD_DATA with the macro, it goes to TURN.
  - IDLE, WRITE or RD_DATA with an accepted read goes to RD_ADDR.
  - IDLE, WRITE or RD_DATA with no accepted request goes to IDLE.
  - RD_ADDR always goes to RD_DATA.
  - TURN always goes to WRITE.
- rsp_valid is high for exactly the one cycle after each RD_DATA cycle. Writes produce no response.
- address is held at its last value in IDLE and TURN.
- The data bus is never driven in RD_ADDR, RD_DATA, TURN or IDLE.

## Timing
- Reset values, applied asynchronously while rst_n=0:
  - state=IDLE.
  - cs, oe, we, rsp_valid, bus-drive enable = 0.
  - address, rsp_rdata, write-data register = 0.
  - req_ready=1 after release.
- Reset mid-operation: the bus is released immediately and any in-flight request is dropped with no rsp_valid. Any write not yet past its WRITE cycle is lost.
- Write latency: accepted at edge E0, WRITE during E0–E1, RAM updated at E1.
- Sustained write throughput: 1 write per cycle.
- Read latency: accepted at E0, RD_ADDR during E0–E1, RD_DATA during E1–E2, rsp_valid=1 during E2–E3.
- Read throughput: 1 read per 2 cycles.
- Read followed by a write in RD_DATA:
  - Without the macro, WRITE starts the next cycle.
  - With the macro, one TURN cycle is inserted first.
- req_ready drops in RD_ADDR and TURN, in the same cycle the state is entered (it is a registered state decode).

## Configuration
- SRAM_PORT_MASTER_TURNAROUND_EN:
  - Defined: a write accepted during RD_DATA passes through TURN, giving one cycle with cs=0 and nobody driving the bus between the RAM releasing the bus and the master driving it.
  - Undefined: TURN does not exist and RD_DATA goes directly to WRITE. This has zero-gap timing and relies on the RAM's output release at the same edge.

## Test plan
- Reset: assert rst_n=0 mid-WRITE. Required: cs/we/bus-drive go to 0 and data goes to Z without waiting for clk; req_ready=1 after release.
- Single write then read: write 0xA5 to address 0x3C, then read 0x3C. Required:
  - cs=we=1 for exactly one cycle with data=0xA5.
  - rsp_valid pulses once, 3 cycles after read acceptance, with rsp_rdata=0xA5.
- Write burst: 4 back-to-back writes to 0x00..0x03 with data 0x10..0x13, req_valid held high. Required: 4 consecutive WRITE cycles, req_ready never drops, RAM contents match.
- Read burst: 3 reads of 0x01, 0x02, 0x03 held valid. Required: req_ready toggles 0/1, one read every 2 cycles, rsp_rdata returns 0x11, 0x12, 0x13 in order.
- Read→write turnaround: read 0x05, then write 0x77 to 0x06 presented during RD_DATA. Required:
  - With the macro: exactly one cycle with cs=0 and data=Z between RD_DATA and WRITE.
  - Without the macro: WRITE follows immediately.
  - In both builds, no cycle has master and RAM driving the bus together.
- Idle hold: no requests for 10 cycles after a read of 0x05. Required: cs=oe=we=0, data=Z, rsp_rdata stays at the 0x05 read value, no rsp_valid pulse.
